// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types and constants for the byte-serialising memory
// controller (mem_ctrl_mc) and its arbiter.
//   mc_state_e : controller FSM states
//   BYTE_W     : RAM bus width
//   IO_HI/LO   : address bits that select the IO region, IO_VAL = region code
//   clamp_len  : maps an out-of-range byte count onto a full word
package mem_ctrl_pkg;

    localparam int         BYTE_W = 8;
    localparam int         IO_HI  = 17;
    localparam int         IO_LO  = 16;
    localparam logic [1:0] IO_VAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DRAIN,
        ST_DONE
    } mc_state_e;

    // 0 and 5..7 are not meaningful byte counts; treat them as a full word.
    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        clamp_len = (len == 3'd0 || len > 3'd4) ? 3'd4 : len;
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: picks one requester out of NCH.
//   clk, rst   : clock, synchronous active-high reset
//   req_i      : request vector
//   gnt_en_i   : the controller accepts the grant this cycle (moves pointer)
//   gnt_o      : one-hot grant (zero when nothing requests)
//   gnt_idx_o  : index of the granted channel
// PRIO_MODE=0 is fixed priority (lowest index wins); PRIO_MODE=1 is
// round-robin where ptr_q names the highest-priority channel.
module mem_rr_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int PRIO_MODE = 0,
    localparam int IDX_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req_i,
    input  logic             gnt_en_i,
    output logic [NCH-1:0]   gnt_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               cand;

    always_comb begin
        found     = 1'b0;
        gnt_idx_o = '0;
        gnt_o     = '0;
        cand      = 0;
        for (int off = 0; off < NCH; off++) begin
            cand = (PRIO_MODE == 1) ? (int'(ptr_q) + off) % NCH : off;
            if (!found && req_i[cand]) begin
                found     = 1'b1;
                gnt_idx_o = IDX_W'(cand);
            end
        end
        if (found) gnt_o[gnt_idx_o] = 1'b1;

        // Pointer only moves when a grant is actually taken.
        ptr_d = ptr_q;
        if (gnt_en_i && found)
            ptr_d = (gnt_idx_o == IDX_W'(NCH - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_ctrl_mc.sv
// mem_ctrl_mc: serialises word accesses from NCH requesters onto a byte-wide
// RAM/IO bus and reassembles read bytes across the RAM read latency.
//   clk, rst          : clock, synchronous active-high reset
//   rdy               : global enable, everything freezes while low
//   req_i/we_i/len_i/addr_i/wdata_i : per-channel request (held until done)
//   done_o            : one-cycle completion pulse per channel
//   rdata_o           : assembled read word, valid with done_o
//   ram_din_i         : RAM read byte (RD_LAT cycles after the address)
//   io_full_i         : IO output buffer full, throttles IO-region writes
//   ram_addr_o/ram_dout_o/ram_wr_o : byte bus, all zero outside issue cycles
module mem_ctrl_mc
    import mem_ctrl_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NCH-1:0]        req_i,
    input  logic [NCH-1:0]        we_i,
    input  logic [NCH*3-1:0]      len_i,
    input  logic [NCH*ADDR_W-1:0] addr_i,
    input  logic [NCH*DATA_W-1:0] wdata_i,
    output logic [NCH-1:0]        done_o,
    output logic [DATA_W-1:0]     rdata_o,
    input  logic [7:0]            ram_din_i,
    input  logic                  io_full_i,
    output logic [ADDR_W-1:0]     ram_addr_o,
    output logic [7:0]            ram_dout_o,
    output logic                  ram_wr_o
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    mc_state_e                   state_q, state_d;
    logic [IDX_W-1:0]            ch_q, ch_d;
    logic                        we_q, we_d;
    logic [2:0]                  len_q, len_d;
    logic [2:0]                  k_q, k_d;          // bytes issued so far
    logic [1:0]                  drain_q, drain_d;  // drain cycles elapsed
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [DATA_W-1:0]           wdata_q, wdata_d;
    logic [DATA_W-1:0]           asm_q, asm_d;      // read assembly register
    // Read-return pipeline: stage i holds a byte issued i+1 cycles ago.
    logic [RD_LAT-1:0]           vld_pipe_q, vld_pipe_d;
    logic [RD_LAT-1:0][1:0]      idx_pipe_q, idx_pipe_d;

    logic [NCH-1:0]              gnt;
    logic [IDX_W-1:0]            gnt_idx;
    logic                        gnt_take, issue, io_stall, cancel;
    logic [ADDR_W-1:0]           cur_addr;
    int                          sel;

    assign gnt_take = rdy && (state_q == ST_IDLE) && (|gnt);

    mem_rr_arbiter #(
        .NCH       (NCH),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .gnt_en_i  (gnt_take),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        cur_addr = addr_q + ADDR_W'(k_q);   // wraps modulo 2^ADDR_W
        io_stall = we_q && io_full_i && (cur_addr[IO_HI:IO_LO] == IO_VAL);
        issue    = (state_q == ST_ACCESS) && !io_stall;
        // Only reads may be abandoned; writes always run to completion.
        cancel   = !we_q && !req_i[ch_q] &&
                   (state_q == ST_ACCESS || state_q == ST_DRAIN);
    end

    always_comb begin
        ram_addr_o = '0;
        ram_dout_o = '0;
        ram_wr_o   = 1'b0;
        done_o     = '0;
        rdata_o    = '0;
        if (issue) begin
            ram_addr_o = cur_addr;
            if (we_q) begin
                ram_dout_o = wdata_q[{k_q[1:0], 3'b000} +: BYTE_W];
                ram_wr_o   = rdy;
            end
        end
        if (state_q == ST_DONE) begin
            rdata_o      = asm_q;
            done_o[ch_q] = rdy;   // a frozen DONE still yields a single pulse
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        we_d       = we_q;
        len_d      = len_q;
        k_d        = k_q;
        drain_d    = drain_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        asm_d      = asm_q;
        vld_pipe_d = vld_pipe_q;
        idx_pipe_d = idx_pipe_q;
        sel        = int'(gnt_idx);

        if (rdy) begin
            vld_pipe_d[0] = issue && !we_q;
            idx_pipe_d[0] = k_q[1:0];
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe_d[i] = vld_pipe_q[i-1];
                idx_pipe_d[i] = idx_pipe_q[i-1];
            end
            if (vld_pipe_q[RD_LAT-1])
                asm_d[{idx_pipe_q[RD_LAT-1], 3'b000} +: BYTE_W] = ram_din_i;

            case (state_q)
                ST_IDLE: begin
                    if (gnt_take) begin
                        state_d    = ST_ACCESS;
                        ch_d       = gnt_idx;
                        we_d       = we_i[sel];
                        len_d      = clamp_len(len_i[sel*3 +: 3]);
                        addr_d     = addr_i[sel*ADDR_W +: ADDR_W];
                        wdata_d    = wdata_i[sel*DATA_W +: DATA_W];
                        k_d        = '0;
                        drain_d    = '0;
                        asm_d      = '0;
                        vld_pipe_d = '0;
                    end
                end
                ST_ACCESS: begin
                    if (cancel) begin
                        state_d    = ST_IDLE;
                        vld_pipe_d = '0;
                    end else if (issue) begin
                        k_d = k_q + 3'd1;
                        if (k_q + 3'd1 == len_q)
                            state_d = we_q ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cancel) begin
                        state_d    = ST_IDLE;
                        vld_pipe_d = '0;
                    end else begin
                        drain_d = drain_q + 2'd1;
                        if (drain_q == 2'(RD_LAT - 1)) state_d = ST_DONE;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            we_q       <= 1'b0;
            len_q      <= '0;
            k_q        <= '0;
            drain_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            asm_q      <= '0;
            vld_pipe_q <= '0;
            idx_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            we_q       <= we_d;
            len_q      <= len_d;
            k_q        <= k_d;
            drain_q    <= drain_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            asm_q      <= asm_d;
            vld_pipe_q <= vld_pipe_d;
            idx_pipe_q <= idx_pipe_d;
        end
    end

endmodule

// File: tb/tb_mem_ctrl_mc.sv
// tb_mem_ctrl_mc: directed + randomized checks of mem_ctrl_mc against a
// transaction-level reference (byte schedule, RAM contents, done timing).
module tb_mem_ctrl_mc;
    localparam int NCH = 2, AW = 32, DW = 32, RDL = 1;

    logic clk = 1'b0;
    logic rst, rdy;
    logic [NCH-1:0]    req_i, we_i;
    logic [NCH*3-1:0]  len_i;
    logic [NCH*AW-1:0] addr_i;
    logic [NCH*DW-1:0] wdata_i;
    logic [NCH-1:0]    done_o;
    logic [DW-1:0]     rdata_o;
    logic [7:0]        ram_din_i;
    logic              io_full_i;
    logic [AW-1:0]     ram_addr_o;
    logic [7:0]        ram_dout_o;
    logic              ram_wr_o;

    // second instance in round-robin mode
    logic [NCH-1:0]    rr_req;
    logic [NCH-1:0]    rr_we = '0;
    logic [NCH*3-1:0]  rr_len = {3'd1, 3'd1};
    logic [NCH*AW-1:0] rr_addr = {32'h40, 32'h20};
    logic [NCH*DW-1:0] rr_wdata = '0;
    logic [NCH-1:0]    rr_done;
    logic [DW-1:0]     rr_rdata;
    logic [7:0]        rr_din = 8'h00;
    logic [AW-1:0]     rr_ram_addr;
    logic [7:0]        rr_ram_dout;
    logic              rr_ram_wr;

    int total = 0, bad = 0;
    logic [7:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    mem_ctrl_mc #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .PRIO_MODE(0)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(req_i), .we_i(we_i), .len_i(len_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o),
        .ram_din_i(ram_din_i), .io_full_i(io_full_i), .ram_addr_o(ram_addr_o),
        .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o));

    mem_ctrl_mc #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RDL), .PRIO_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .rdy(rdy), .req_i(rr_req), .we_i(rr_we), .len_i(rr_len),
        .addr_i(rr_addr), .wdata_i(rr_wdata), .done_o(rr_done), .rdata_o(rr_rdata),
        .ram_din_i(rr_din), .io_full_i(io_full_i), .ram_addr_o(rr_ram_addr),
        .ram_dout_o(rr_ram_dout), .ram_wr_o(rr_ram_wr));

    function automatic logic [7:0] mrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // RAM model (latency 1, stalled by rdy), then advance to just after the edge.
    task automatic adv();
        logic [7:0] nx;
        logic       rs;
        rs = rdy;
        nx = mrd(ram_addr_o);
        if (rdy && ram_wr_o) mem[ram_addr_o] = ram_dout_o;
        @(posedge clk); #1;
        if (rs) ram_din_i = nx;
    endtask

    task automatic setup(input int ch, input logic we, input int len,
                         input logic [31:0] a, input logic [31:0] wd);
        we_i[ch]            = we;
        len_i[ch*3 +: 3]    = 3'(len);
        addr_i[ch*AW +: AW] = a;
        wdata_i[ch*DW +: DW] = wd;
        req_i[ch]           = 1'b1;
    endtask

    // Current cycle is the grant cycle T; returns just after the done cycle.
    task automatic expect_txn(input int ch, input logic we, input int len_raw,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int full_n, input int gap_at, input int gap_n);
        int len, k, dr;
        logic [31:0] ex, ba;
        logic [1:0]  exp_done;
        logic        fin;
        len = (len_raw < 1 || len_raw > 4) ? 4 : len_raw;
        ex = '0;
        for (int i = 0; i < len; i++) ex[8*i +: 8] = mrd(a + 32'(i));
        exp_done = '0;
        exp_done[ch] = 1'b1;
        settle();
        chk("grant_cycle_done", done_o, 0);
        chk("grant_cycle_wr", ram_wr_o, 0);
        adv();
        k = 0; dr = 0; fin = 1'b0;
        for (int j = 0; j < 40 && !fin; j++) begin
            rdy       = !(j >= gap_at && j < gap_at + gap_n);
            io_full_i = (j < full_n);
            settle();
            ba = a + 32'(k);
            if (k < len) begin
                if (!rdy) chk("frozen_wr", ram_wr_o, 0);
                else if (we && ba[17:16] == 2'b11 && io_full_i) begin
                    chk("io_stall_addr", ram_addr_o, 0);
                    chk("io_stall_wr", ram_wr_o, 0);
                end else begin
                    chk("issue_addr", ram_addr_o, ba);
                    chk("issue_wr", ram_wr_o, we);
                    if (we) chk("issue_dout", ram_dout_o, wd[8*k +: 8]);
                    k++;
                end
                chk("early_done", done_o, 0);
            end else if (!we && dr < RDL) begin
                chk("drain_addr", ram_addr_o, 0);
                chk("drain_wr", ram_wr_o, 0);
                chk("drain_done", done_o, 0);
                chk("drain_rdata", rdata_o, 0);
                if (rdy) dr++;
            end else if (!rdy) begin
                chk("frozen_done", done_o, 0);
            end else begin
                chk("done", done_o, exp_done);
                if (!we) chk("rdata", rdata_o, ex);
                chk("done_bus_idle", ram_addr_o, 0);
                fin = 1'b1;
            end
            adv();
        end
        rdy = 1'b1;
        io_full_i = 1'b0;
        if (!fin) chk("txn_timeout", 0, 1);
    endtask

    task automatic release_ch(input int ch);
        req_i[ch] = 1'b0;
        settle();
        chk("single_pulse", done_o, 0);
        adv();
    endtask

    initial begin
        logic [1:0] seq [4];
        int n, ch, len, full_n, gap_at, gap_n;
        logic we;
        logic [31:0] a, wd;

        rst = 1'b1; rdy = 1'b1; req_i = '0; we_i = '0; len_i = '0; addr_i = '0;
        wdata_i = '0; ram_din_i = '0; io_full_i = 1'b0; rr_req = '0;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_done", done_o, 0);
        chk("rst_rdata", rdata_o, 0);
        chk("rst_addr", ram_addr_o, 0);
        chk("rst_dout", ram_dout_o, 0);
        chk("rst_wr", ram_wr_o, 0);
        chk("rst_rr_done", rr_done, 0);
        adv();
        rst = 1'b0;
        settle(); adv();

        // ch1 read of four known bytes
        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        setup(1, 1'b0, 4, 32'h100, 32'h0);
        expect_txn(1, 1'b0, 4, 32'h100, 32'h0, 0, 0, 0);
        release_ch(1);

        // simultaneous requests: ch0 write wins, ch1 granted right after
        setup(0, 1'b1, 2, 32'h200, 32'h0000BEEF);
        setup(1, 1'b0, 3, 32'h300, 32'h0);
        expect_txn(0, 1'b1, 2, 32'h200, 32'h0000BEEF, 0, 0, 0);
        req_i[0] = 1'b0;
        expect_txn(1, 1'b0, 3, 32'h300, 32'h0, 0, 0, 0);
        release_ch(1);
        chk("mem_wr_lo", mem[32'h200], 8'hEF);

        // IO write throttled for three cycles
        setup(0, 1'b1, 1, 32'h30000, 32'h000000A5);
        expect_txn(0, 1'b1, 1, 32'h30000, 32'h000000A5, 3, 0, 0);
        release_ch(0);

        // read cancel: req dropped in T+2
        setup(1, 1'b0, 4, 32'h500, 32'h0);
        settle(); adv();
        settle(); chk("cancel_pre_addr", ram_addr_o, 32'h500); adv();
        req_i[1] = 1'b0;
        settle(); adv();
        settle();
        chk("cancel_idle_addr", ram_addr_o, 0);
        chk("cancel_idle_wr", ram_wr_o, 0);
        chk("cancel_no_done", done_o, 0);
        adv();
        repeat (4) begin settle(); chk("cancel_no_done", done_o, 0); adv(); end
        setup(1, 1'b0, 2, 32'h600, 32'h0);
        expect_txn(1, 1'b0, 2, 32'h600, 32'h0, 0, 0, 0);
        release_ch(1);

        // rdy low for two cycles mid read
        setup(0, 1'b0, 4, 32'h700, 32'h0);
        expect_txn(0, 1'b0, 4, 32'h700, 32'h0, 0, 1, 2);
        release_ch(0);

        // illegal lengths act as four bytes; write then read back
        setup(0, 1'b1, 7, 32'h900, 32'hCAFEF00D);
        expect_txn(0, 1'b1, 7, 32'h900, 32'hCAFEF00D, 0, 0, 0);
        release_ch(0);
        setup(1, 1'b0, 0, 32'h900, 32'h0);
        expect_txn(1, 1'b0, 0, 32'h900, 32'h0, 0, 0, 0);
        release_ch(1);

        // address wraps past 2^32
        setup(0, 1'b0, 4, 32'hFFFFFFFE, 32'h0);
        expect_txn(0, 1'b0, 4, 32'hFFFFFFFE, 32'h0, 0, 0, 0);
        release_ch(0);

        // randomized transactions
        for (int r = 0; r < 12; r++) begin
            ch     = int'($urandom_range(0, 1));
            we     = 1'($urandom_range(0, 1));
            len    = int'($urandom_range(1, 4));
            a      = $urandom;
            if ($urandom_range(0, 1) == 1) a[17:16] = 2'b11;
            wd     = $urandom;
            full_n = int'($urandom_range(0, 2));
            gap_at = int'($urandom_range(0, 5));
            gap_n  = int'($urandom_range(0, 2));
            setup(ch, we, len, a, wd);
            expect_txn(ch, we, len, a, wd, full_n, gap_at, gap_n);
            release_ch(ch);
        end

        // reset in the middle of a read
        setup(1, 1'b0, 4, 32'h1000, 32'h0);
        settle(); adv();
        settle(); adv();
        rst = 1'b1;
        settle(); adv();
        rst = 1'b0;
        req_i[1] = 1'b0;
        settle();
        chk("midrst_done", done_o, 0);
        chk("midrst_rdata", rdata_o, 0);
        chk("midrst_addr", ram_addr_o, 0);
        chk("midrst_wr", ram_wr_o, 0);
        adv();
        repeat (4) begin settle(); chk("midrst_no_done", done_o, 0); adv(); end

        // round-robin instance: both channels request continuously
        rr_req = 2'b11;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            settle();
            if (rr_done != '0) begin seq[n] = rr_done; n++; end
            adv();
        end
        rr_req = '0;
        chk("rr_count", n, 4);
        if (n == 4) begin
            chk("rr_grant0", seq[0], 2'b01);
            chk("rr_grant1", seq[1], 2'b10);
            chk("rr_grant2", seq[2], 2'b01);
            chk("rr_grant3", seq[3], 2'b10);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_ctrl_mc.md
Name: mem_ctrl_mc

Overview:
- Sequential, parametrised memory controller between NCH pipeline requesters (data port, instruction fetch, ...) and the single byte-wide RAM/IO bus.
- Each requester issues one word-level access of 1..4 bytes. The controller serialises it into byte cycles, reassembles read bytes across the RAM read latency, and returns one done pulse.
- Adds over the previous combinational arbiter: multi-byte transactions, fixed or round-robin priority, IO-buffer-full write throttling, and read cancellation.

Parameters:
- NCH, 2, number of requester channels; channel 0 = data port.
- ADDR_W, 32, address width.
- DATA_W, 32, word width; must equal 4*8.
- RD_LAT, 1, RAM read latency in cycles; legal range 1..3.
- PRIO_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low, all state is frozen
- req_i  in  NCH  per-channel request; held high until done_o
- we_i  in  NCH  per-channel write enable
- len_i  in  NCH*3  per-channel byte count, 1..4
- addr_i  in  NCH*ADDR_W  per-channel base byte address
- wdata_i  in  NCH*DATA_W  per-channel write data, little-endian
- done_o  out  NCH  one-cycle completion pulse
- rdata_o  out  DATA_W  read data, valid while any done_o bit is high
- ram_din_i  in  8  RAM read byte
- io_full_i  in  1  IO output buffer full
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_dout_o  out  8  RAM write byte
- ram_wr_o  out  1  RAM write strobe

Behaviour:
- Reset values: done_o=0, rdata_o=0, ram_addr_o=0, ram_dout_o=0, ram_wr_o=0; FSM to IDLE; round-robin pointer to channel 0.
- FSM states:
  - IDLE → ACCESS on grant.
  - ACCESS → DRAIN after the last byte issues on a read; ACCESS → DONE after the last byte issues on a write.
  - DRAIN → DONE after RD_LAT cycles.
  - DONE → IDLE.
- Grant (cycle T, IDLE, any req_i high):
  - Arbiter picks a channel.
  - Latch channel, we, len, addr, wdata; clear the assembly register.
- Issue: byte k (0..len-1) is driven in cycle T+1+k.
  - ram_addr_o = addr+k, computed modulo 2^ADDR_W so the address wraps.
  - Writes: ram_wr_o=1, ram_dout_o = wdata[8k+7:8k].
- Read capture: ram_din_i is sampled RD_LAT cycles after issue into byte lane k, via a shift register of byte indices RD_LAT deep.
- Completion:
  - done_o[ch] is high for exactly one cycle: T+len+RD_LAT+1 for reads, T+len+1 for writes.
  - Read lanes >= len are zero in rdata_o.
  - RD_LAT=1, len=4 read: grant T, done T+6.
- Idle bus: outside issue cycles, ram_addr_o=0, ram_wr_o=0, ram_dout_o=0.
- Arbitration:
  - PRIO_MODE=0: lowest-index requester wins.
  - PRIO_MODE=1: the channel after the last grant has highest priority; the pointer updates on grant only.
  - Requests arriving mid-transaction wait; there is no preemption.
- IO throttle: if a write byte's address has addr[17:16]==2'b11 and io_full_i=1, that byte is not issued.
  - ram_wr_o=0, ram_addr_o=0, byte index held.
  - The byte issues in the first cycle io_full_i=0; done_o is delayed by the stall count.
- Read cancel: if req_i[ch] falls during ACCESS/DRAIN of a read, the FSM goes to IDLE next cycle with no done_o. In-flight RAM bytes are discarded.
- Writes cannot be cancelled; they run to DONE regardless of req_i.
- rdy low: no state, counter or capture advances, and ram_wr_o=0. Resumes exactly where frozen; the RAM is stalled by the same rdy.
- Illegal len (0, 5..7): treated as 4.
- Reset mid-transaction: abort with no done pulse; outputs at reset values next cycle.
- A new grant is possible in the cycle after DONE, i.e. at the earliest 1 cycle after done_o.

Decomposition:
- Package mem_ctrl_pkg:
  - FSM state enum (IDLE/ACCESS/DRAIN/DONE)
  - BYTE_W=8
  - IO region constants (bit positions 17:16, value 2'b11)
  - len clamp function
- Sub-module mem_rr_arbiter (NCH, PRIO_MODE): req vector in, grant strobe in, one-hot grant + index out, internal pointer.

Test Plan:
- Ch1 read len=4 at 0x100, RAM bytes 11,22,33,44, RD_LAT=1 → ram_addr_o 0x100..0x103 in T+1..T+4; done_o=2'b10 at T+6; rdata_o=0x44332211.
- Ch0 write len=2 at 0x200, wdata=0xBEEF, and ch1 read requested same cycle, PRIO_MODE=0 → ch0 first: ram_wr_o=1 with bytes EF,BE at 0x200/0x201; done_o[0] at T+3; ch1 granted at T+4.
- PRIO_MODE=1, both channels requesting continuously → grants alternate 0,1,0,1.
- Write len=1 to 0x30000 with io_full_i=1 for 3 cycles → no ram_wr_o for 3 cycles; then ram_wr_o=1 at 0x30000; done_o delayed by 3 cycles.
- Ch1 read len=4, req_i[1] dropped at T+2 → FSM in IDLE at T+3, done_o never asserts; next request granted normally.
- rdy=0 for 2 cycles mid len=4 read → done_o 2 cycles later, rdata_o correct.
- rst asserted at T+2 → all outputs 0 next cycle, no done pulse.
